// File: rtl/bmp_pkg.sv
// Shared constants and state encoding for the BMP byte-stream parser.
package bmp_pkg;

  localparam int HDR_LEN = 54;

  localparam logic [7:0] BMP_SIG0 = 8'h42;
  localparam logic [7:0] BMP_SIG1 = 8'h4D;

  localparam logic [5:0] OFF_SIG0   = 6'd0;
  localparam logic [5:0] OFF_SIG1   = 6'd1;
  localparam logic [5:0] OFF_BITS   = 6'd10;
  localparam logic [5:0] OFF_WIDTH  = 6'd18;
  localparam logic [5:0] OFF_HEIGHT = 6'd22;
  localparam logic [5:0] OFF_BPP    = 6'd28;
  localparam logic [5:0] OFF_COMP   = 6'd30;

  localparam logic [15:0] BPP_24 = 16'd24;

  typedef logic [2:0] state_t;
  localparam state_t ST_HDR  = 3'd0;
  localparam state_t ST_SKIP = 3'd1;
  localparam state_t ST_PIXB = 3'd2;
  localparam state_t ST_PIXG = 3'd3;
  localparam state_t ST_PIXR = 3'd4;
  localparam state_t ST_ERR  = 3'd5;

  function automatic logic in_field(input logic [5:0] idx, input logic [5:0] base,
                                    input logic [5:0] len);
    return (idx >= base) && (idx < base + len);
  endfunction

endpackage

// File: rtl/bmp_hdr_capture.sv
// Little-endian header field capture and header validity checks.
module bmp_hdr_capture
  import bmp_pkg::*;
#(
  parameter int MAX_WIDTH  = 768,
  parameter int MAX_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [5:0]  byte_idx,
  input  logic [7:0]  byte_data,
  output logic [15:0] width,
  output logic [15:0] height,
  output logic [15:0] offset,
  output logic        pass
);

  logic [7:0]  sig0, sig1;
  logic [31:0] off_f, wid_f, hgt_f, comp_f;
  logic [15:0] bpp_f;

  // Multi-byte fields shift in from the top so the first (least significant) byte lands lowest.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig0   <= '0;
      sig1   <= '0;
      off_f  <= '0;
      wid_f  <= '0;
      hgt_f  <= '0;
      comp_f <= '0;
      bpp_f  <= '0;
    end else if (byte_en) begin
      if (byte_idx == OFF_SIG0) sig0 <= byte_data;
      if (byte_idx == OFF_SIG1) sig1 <= byte_data;
      if (in_field(byte_idx, OFF_BITS, 6'd4))   off_f  <= {byte_data, off_f[31:8]};
      if (in_field(byte_idx, OFF_WIDTH, 6'd4))  wid_f  <= {byte_data, wid_f[31:8]};
      if (in_field(byte_idx, OFF_HEIGHT, 6'd4)) hgt_f  <= {byte_data, hgt_f[31:8]};
      if (in_field(byte_idx, OFF_BPP, 6'd2))    bpp_f  <= {byte_data, bpp_f[15:8]};
      if (in_field(byte_idx, OFF_COMP, 6'd4))   comp_f <= {byte_data, comp_f[31:8]};
    end
  end

  logic sig_ok, fmt_ok, wid_ok, hgt_ok, off_ok;

  // Negative (top-down) dimensions appear as huge unsigned values and fail the range checks.
  always_comb begin
    sig_ok = (sig0 == BMP_SIG0) && (sig1 == BMP_SIG1);
    fmt_ok = (bpp_f == BPP_24) && (comp_f == 32'd0);
    wid_ok = (wid_f != 32'd0) && (wid_f <= 32'(MAX_WIDTH));
    hgt_ok = (hgt_f != 32'd0) && (hgt_f <= 32'(MAX_HEIGHT));
    off_ok = (off_f >= 32'(HDR_LEN)) && (off_f < 32'd65536);
    pass   = sig_ok && fmt_ok && wid_ok && hgt_ok && off_ok;
  end

  assign width  = wid_f[15:0];
  assign height = hgt_f[15:0];
  assign offset = off_f[15:0];

endmodule

// File: rtl/bmp_stream_parser.sv
// Byte-stream 24-bit BMP decoder emitting RGB pixels in file order.
// Optional gray output enabled by defining BMP_STREAM_PARSER_GRAY_EN.
module bmp_stream_parser
  import bmp_pkg::*;
#(
  parameter int MAX_WIDTH  = 768,
  parameter int MAX_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        out_eol,
  output logic        out_last,
`ifdef BMP_STREAM_PARSER_GRAY_EN
  output logic [7:0]  out_gray,
`endif
  output logic [15:0] img_width,
  output logic [15:0] img_height,
  output logic        hdr_ok,
  output logic        err
);

  state_t      state;
  logic [15:0] byte_cnt, offset_r, col, row;
  logic [1:0]  pad_cnt;
  logic        frame_done;
  logic [7:0]  b_lat, g_lat;

  logic [15:0] cap_width, cap_height, cap_offset;
  logic        cap_pass;
  logic        byte_acc, pix_take, is_eol, is_last, frame_end;

  bmp_hdr_capture #(
    .MAX_WIDTH (MAX_WIDTH),
    .MAX_HEIGHT(MAX_HEIGHT)
  ) u_hdr (
    .clk      (clk),
    .rst      (rst),
    .byte_en  (byte_acc && (state == ST_HDR)),
    .byte_idx (byte_cnt[5:0]),
    .byte_data(in_data),
    .width    (cap_width),
    .height   (cap_height),
    .offset   (cap_offset),
    .pass     (cap_pass)
  );

  // Only the R byte writes the single output register, so only it waits on downstream.
  always_comb begin
    in_ready  = (state == ST_PIXR) ? (!out_valid || out_ready) : (state != ST_ERR);
    byte_acc  = in_valid && in_ready;
    pix_take  = out_valid && out_ready;
    is_eol    = (col == img_width - 16'd1);
    is_last   = is_eol && (row == img_height - 16'd1);
    frame_end = byte_acc &&
                (((state == ST_PIXB) && (pad_cnt == 2'd1) && frame_done) ||
                 ((state == ST_PIXR) && is_last && (img_width[1:0] == 2'b00)));
  end

`ifdef BMP_STREAM_PARSER_GRAY_EN
  logic [9:0] gray_sum;
  assign gray_sum = {2'b00, in_data} + {1'b0, g_lat, 1'b0} + {2'b00, b_lat};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HDR;
      byte_cnt   <= '0;
      offset_r   <= '0;
      col        <= '0;
      row        <= '0;
      pad_cnt    <= '0;
      frame_done <= 1'b0;
      b_lat      <= '0;
      g_lat      <= '0;
      out_valid  <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_eol    <= 1'b0;
      out_last   <= 1'b0;
`ifdef BMP_STREAM_PARSER_GRAY_EN
      out_gray   <= '0;
`endif
      img_width  <= '0;
      img_height <= '0;
      hdr_ok     <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (pix_take) out_valid <= 1'b0;
      case (state)
        ST_HDR: if (byte_acc) begin
          byte_cnt <= byte_cnt + 16'd1;
          if (byte_cnt == 16'(HDR_LEN - 1)) begin
            if (cap_pass) begin
              hdr_ok     <= 1'b1;
              img_width  <= cap_width;
              img_height <= cap_height;
              offset_r   <= cap_offset;
              state      <= (cap_offset > 16'(HDR_LEN)) ? ST_SKIP : ST_PIXB;
            end else begin
              err   <= 1'b1;
              state <= ST_ERR;
            end
          end
        end
        ST_SKIP: if (byte_acc) begin
          byte_cnt <= byte_cnt + 16'd1;
          if (byte_cnt + 16'd1 == offset_r) state <= ST_PIXB;
        end
        // Pending row padding is swallowed here before the next B byte is taken.
        ST_PIXB: if (byte_acc) begin
          if (pad_cnt != 2'd0) begin
            pad_cnt <= pad_cnt - 2'd1;
          end else begin
            b_lat <= in_data;
            state <= ST_PIXG;
          end
        end
        ST_PIXG: if (byte_acc) begin
          g_lat <= in_data;
          state <= ST_PIXR;
        end
        ST_PIXR: if (byte_acc) begin
          out_valid <= 1'b1;
          out_r     <= in_data;
          out_g     <= g_lat;
          out_b     <= b_lat;
          out_eol   <= is_eol;
          out_last  <= is_last;
`ifdef BMP_STREAM_PARSER_GRAY_EN
          out_gray  <= 8'(gray_sum >> 2);
`endif
          state     <= ST_PIXB;
          if (is_eol) begin
            col     <= '0;
            row     <= row + 16'd1;
            pad_cnt <= img_width[1:0];
            if (is_last) frame_done <= 1'b1;
          end else begin
            col <= col + 16'd1;
          end
        end
        default: ;
      endcase
      if (frame_end) begin
        state      <= ST_HDR;
        byte_cnt   <= '0;
        col        <= '0;
        row        <= '0;
        pad_cnt    <= '0;
        frame_done <= 1'b0;
        hdr_ok     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Scoreboard bench for bmp_stream_parser: builds BMP byte streams, checks decoded pixels.
module tb_bmp_stream_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_eol, out_last;
  logic [15:0] img_width, img_height;
  logic        hdr_ok, err;
`ifdef BMP_STREAM_PARSER_GRAY_EN
  logic [7:0]  out_gray;
`endif

  bmp_stream_parser dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .out_eol   (out_eol),
    .out_last  (out_last),
`ifdef BMP_STREAM_PARSER_GRAY_EN
    .out_gray  (out_gray),
`endif
    .img_width (img_width),
    .img_height(img_height),
    .hdr_ok    (hdr_ok),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       eol, lst;
  } pix_t;

  pix_t       sb[$];
  logic [7:0] byte_q[$];
  int         total = 0;
  int         bad = 0;
  int         ready_mode = 0;
  int         hdr_rise = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Downstream model: pattern-driven out_ready, scoreboard pop on each pixel transfer.
  initial begin
    int   cyc = 0;
    logic hdr_prev = 1'b0;
    pix_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'b0;
      endcase
      #1;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("extra_pixel", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("pix_rgb", {8'h00, out_r, out_g, out_b}, {8'h00, e.r, e.g, e.b});
          checkOutput("pix_flags", {30'd0, out_eol, out_last}, {30'd0, e.eol, e.lst});
`ifdef BMP_STREAM_PARSER_GRAY_EN
          checkOutput("pix_gray", 32'(out_gray),
                      32'((int'(e.r) + 2 * int'(e.g) + int'(e.b)) / 4));
`endif
        end
      end
      if (hdr_ok && !hdr_prev) hdr_rise++;
      hdr_prev = hdr_ok;
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #2;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic applyStimulus(input int limit);
    int n = 0;
    while (byte_q.size() != 0 && n < limit) begin
      sendByte(byte_q.pop_front());
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pushHeader(input logic [7:0] sig1, input logic [31:0] w, input logic [31:0] h,
                            input logic [31:0] off);
    logic [7:0] hb[54];
    for (int i = 0; i < 54; i++) hb[i] = 8'h00;
    hb[0] = 8'h42;
    hb[1] = sig1;
    for (int i = 0; i < 4; i++) begin
      hb[10 + i] = off[8*i +: 8];
      hb[18 + i] = w[8*i +: 8];
      hb[22 + i] = h[8*i +: 8];
    end
    hb[14] = 8'd40;
    hb[26] = 8'd1;
    hb[28] = 8'd24;
    for (int i = 0; i < 54; i++) byte_q.push_back(hb[i]);
  endtask

  // Pixel data in file order: skipped gap, then BGR triplets, rows padded to 4 bytes.
  task automatic pushPixels(input int w, input int h, input int off);
    int   pad = (4 - ((3 * w) % 4)) % 4;
    pix_t p;
    for (int i = 54; i < off; i++) byte_q.push_back(8'hCC);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        p.r   = 8'($urandom_range(0, 255));
        p.g   = 8'($urandom_range(0, 255));
        p.b   = 8'($urandom_range(0, 255));
        p.eol = (x == w - 1);
        p.lst = (x == w - 1) && (y == h - 1);
        byte_q.push_back(p.b);
        byte_q.push_back(p.g);
        byte_q.push_back(p.r);
        sb.push_back(p);
      end
      for (int k = 0; k < pad; k++) byte_q.push_back(8'hEE);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #2;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  task automatic frameTest(input int w, input int h, input int off);
    pushHeader(8'h4D, 32'(w), 32'(h), 32'(off));
    applyStimulus(100000);
    @(negedge clk);
    #2;
    checkOutput("hdr_ok_set", 32'(hdr_ok), 32'd1);
    checkOutput("img_width", 32'(img_width), 32'(w));
    checkOutput("img_height", 32'(img_height), 32'(h));
    pushPixels(w, h, off);
    applyStimulus(100000);
    waitDrain();
    checkOutput("hdr_ok_clr", 32'(hdr_ok), 32'd0);
  endtask

  initial begin
    int rise0;
    logic [31:0] bad_w[3];
    logic [31:0] bad_h[3];
    logic [7:0]  bad_s[3];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_rgb", {8'h00, out_r, out_g, out_b}, 32'd0);
    checkOutput("rst_flags", {30'd0, out_eol, out_last}, 32'd0);
    checkOutput("rst_dims", {img_width, img_height}, 32'd0);
    checkOutput("rst_hdr_err", {30'd0, hdr_ok, err}, 32'd0);

    ready_mode = 0;
    frameTest(4, 2, 54);
    frameTest(3, 2, 54);
    ready_mode = 1;
    frameTest(4, 2, 54);
    frameTest(3, 2, 54);
    ready_mode = 0;
    frameTest(2, 2, 60);

    // Reset with a pixel held and a partial row in flight.
    ready_mode = 2;
    pushHeader(8'h4D, 32'd4, 32'd2, 32'd54);
    pushPixels(4, 2, 54);
    applyStimulus(58);
    repeat (2) @(negedge clk);
    #2;
    checkOutput("mid_held", 32'(out_valid), 32'd1);
    doReset();
    sb.delete();
    byte_q.delete();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_hdr", 32'(hdr_ok), 32'd0);
    ready_mode = 0;
    frameTest(2, 2, 54);

    // Two frames with no gap between them.
    ready_mode = 1;
    rise0 = hdr_rise;
    pushHeader(8'h4D, 32'd3, 32'd2, 32'd54);
    pushPixels(3, 2, 54);
    pushHeader(8'h4D, 32'd5, 32'd1, 32'd56);
    pushPixels(5, 1, 56);
    applyStimulus(100000);
    waitDrain();
    checkOutput("b2b_hdr_rises", 32'(hdr_rise - rise0), 32'd2);
    ready_mode = 0;

    // Rejected headers: bad signature, width over limit, negative height.
    bad_s[0] = 8'h4E; bad_w[0] = 32'd4;   bad_h[0] = 32'd2;
    bad_s[1] = 8'h4D; bad_w[1] = 32'd769; bad_h[1] = 32'd2;
    bad_s[2] = 8'h4D; bad_w[2] = 32'd4;   bad_h[2] = 32'hFFFF_FFFE;
    for (int t = 0; t < 3; t++) begin
      doReset();
      pushHeader(bad_s[t], bad_w[t], bad_h[t], 32'd54);
      applyStimulus(100000);
      repeat (2) @(negedge clk);
      #2;
      checkOutput("bad_err", 32'(err), 32'd1);
      checkOutput("bad_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bad_out_valid", 32'(out_valid), 32'd0);
      checkOutput("bad_hdr_ok", 32'(hdr_ok), 32'd0);
    end

    checkOutput("sb_final", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
